// File: rtl/nand_dec_rr_arbiter.sv
// Four-requester round-robin arbiter with hold timeout and global enable.
// Registered one-hot grant plus encoded index drives the decoder selects.
module nand_dec_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit TO_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] idx_nx;
  logic       vld_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [3:0] others;
  logic [2:0] hit_idle, hit_oth;
  logic       rel;

  // {found, index} of first set bit of m, searching from p upward mod 4
  function automatic logic [2:0] pick(
    input logic [3:0] m,
    input logic [1:0] p
  );
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (m[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = gnt_idx;
    vld_nx   = gnt_vld;
    hold_nx  = hold_cnt;
    others   = req & ~(4'b0001 << gnt_idx);
    hit_idle = pick(req, ptr);
    hit_oth  = pick(others, gnt_idx + 2'd1);
    rel      = !req[gnt_idx] || !en ||
               (TO_EN && hold_cnt == HOLD_LAST);
    unique case (state)
      IDLE: begin
        if (en && hit_idle[2]) begin
          state_nx = BUSY;
          idx_nx   = hit_idle[1:0];
          vld_nx   = 1'b1;
          hold_nx  = 8'd0;
        end else begin
          idx_nx = 2'd0;
          vld_nx = 1'b0;
        end
      end
      BUSY: begin
        if (!rel) begin
          if (hold_cnt != 8'hff) hold_nx = hold_cnt + 8'd1;
        end else if (!en) begin
          state_nx = IDLE;
          idx_nx   = 2'd0;
          vld_nx   = 1'b0;
          hold_nx  = 8'd0;
        end else begin
          ptr_nx  = gnt_idx + 2'd1;
          hold_nx = 8'd0;
          if (hit_oth[2]) begin
            idx_nx = hit_oth[1:0];
          end else if (!req[gnt_idx]) begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            vld_nx   = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt_idx  <= 2'd0;
      gnt_vld  <= 1'b0;
      gnt      <= 4'b0000;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt_idx  <= idx_nx;
      gnt_vld  <= vld_nx;
      gnt      <= vld_nx ? (4'b0001 << idx_nx) : 4'b0000;
    end
  end

endmodule

// File: doc/nand_dec_rr_arbiter.md
# nand_dec_rr_arbiter

Four-requester round-robin arbiter for the shared 2-to-4 decoded resource. It produces a registered 2-bit grant index plus enable, and decodes them into a one-hot active-high grant vector. The vector drives the select lines of the downstream decoder-based datapath. It adds grant hold, a fairness timeout and a global enable, so four agents can share the resource without starvation.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant; 0 disables the timeout. Legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 blocks new grants and revokes the current grant.
- req  input  4  request per agent, level-sensitive; req[i] is held until service is complete.
- gnt  output  4  one-hot grant; all zero when no grant is active.
- gnt_idx  output  2  encoded index of the granted agent; valid only when gnt_vld=1.
- gnt_vld  output  1  a grant is active; equals |gnt.

## Operation
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0.
- ptr: the highest-priority agent.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4; 3 wraps to 0.
- gnt is the decode of {gnt_vld, gnt_idx}:
  - gnt[i] = gnt_vld & (gnt_idx==i).
  - All three outputs come straight from registers with no combinational path from req.
- State IDLE:
  - en=1 and req!=0: grant the first requesting agent in search order; set hold_cnt=0; go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
- State BUSY (granted agent g): a release event occurs on any of the following.
  - req[g]=0.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - en=0.
- BUSY with no release: hold the grant and increment hold_cnt (saturating at 255).
- BUSY on release with en=1:
  - Set ptr=g+1 mod 4.
  - Search the requesters other than g starting at the new ptr; if one is found, grant it back-to-back with no idle cycle, reset hold_cnt=0 and stay in BUSY.
  - If none is found but req[g]=1 (timeout case), re-grant g with hold_cnt=0.
  - Otherwise go to IDLE with outputs zero.
- BUSY on release with en=0: go to IDLE, clear outputs, leave ptr unchanged.
- ptr changes only on release of an active grant, never in IDLE.
- Requests that arrive while BUSY wait for the current release. Requests that drop before being granted are ignored.

## Timing
- Grant latency is one cycle. If req is sampled high at edge k in IDLE, the outputs are valid after edge k.
- Release latency is one cycle. If req[g] is sampled low at edge m, gnt changes after edge m to either the next agent or zero.
- Timeout: a continuously requesting agent holds gnt for exactly MAX_HOLD cycles when another agent is waiting.
- With MAX_HOLD=1, each grant lasts one cycle, so the arbiter rotates every cycle under full load.
- en deassertion removes the grant after the next edge. en reassertion allows a grant after the following edge.
- Mid-operation reset clears all state asynchronously; the first grant after reset release goes to the lowest requesting index ≥0.
- All req bits changing in the same cycle as a release are resolved with the req values sampled at that edge.

## Test plan
- Reset: assert rst_n=0 mid-grant → gnt=0000, gnt_vld=0 immediately. After release, req=4'b1010 → gnt=0010, gnt_idx=1.
- Rotation: req=1111 held, MAX_HOLD=2 → gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001…
- Back-to-back: grant on agent 0, req=0101, then req[0] drops → gnt=0100 on the next cycle with no zero cycle between grants; afterwards ptr=1.
- Wrap-around: agent 3 granted with req=1001, then req[3] drops → gnt=0001 (3→0 wrap).
- Timeout re-grant: MAX_HOLD=3, only req[2]=1 → gnt=0100 continuously, with hold_cnt cycling 0,1,2,0.
- Enable and disable: MAX_HOLD=0 with req=0011 held 20 cycles → agent 0 keeps its grant throughout. Then en=0 → gnt=0000 after one edge, and ptr stays 0. Then en=1 → gnt=0001 again.
